// File: rtl/timer_alarm_ctrl.sv
// ============================================================================
// Module  : timer_alarm_ctrl
// Brief   : Prescaled 32-bit tick counter with NUM_CH one-shot/periodic alarms
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_alarm_ctrl #(
  parameter int          NUM_CH        = 4,
  parameter logic [31:0] PRESC_DEFAULT = 32'h0001_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic [31:0] addr,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq,
  output logic        tick_out
);

  localparam logic [3:0] c_A_CTRL  = 4'h0;
  localparam logic [3:0] c_A_PRESC = 4'h1;
  localparam logic [3:0] c_A_NOW   = 4'h2;
  localparam logic [3:0] c_A_PEND  = 4'h3;
  localparam logic [3:0] c_A_IEN   = 4'h4;

  logic              r_en;
  logic [NUM_CH-1:0] r_arm;
  logic [NUM_CH-1:0] r_pend;
  logic [NUM_CH-1:0] r_ien;
  logic [31:0]       r_presc;
  logic [31:0]       r_presc_cnt;
  logic              r_tick_q;
  logic [31:0]       r_now;
  logic [31:0]       r_cmp    [NUM_CH];
  logic [31:0]       r_period [NUM_CH];

  logic [3:0]        w_sel;
  logic              w_wr;
  logic              w_wr_ctrl;
  logic              w_wr_presc;
  logic              w_wr_now;
  logic              w_wr_pend;
  logic              w_wr_ien;
  logic [NUM_CH-1:0] w_wr_cmp;
  logic [NUM_CH-1:0] w_wr_per;
  logic [NUM_CH-1:0] w_fire;
  logic [NUM_CH-1:0] w_w1c;
  logic              w_unused;

  assign w_sel      = addr[5:2];
  assign w_wr       = cs && we;
  assign w_wr_ctrl  = w_wr && (w_sel == c_A_CTRL);
  assign w_wr_presc = w_wr && (w_sel == c_A_PRESC);
  assign w_wr_now   = w_wr && (w_sel == c_A_NOW);
  assign w_wr_pend  = w_wr && (w_sel == c_A_PEND);
  assign w_wr_ien   = w_wr && (w_sel == c_A_IEN);
  assign w_w1c      = w_wr_pend ? wdata[NUM_CH-1:0] : '0;
  assign w_unused   = ^{addr[31:6], addr[1:0]};

  // Matches use the pre-increment NOW of the tick cycle.
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    assign w_wr_cmp[i] = w_wr && (w_sel == 4'(8 + i));
    assign w_wr_per[i] = w_wr && (w_sel == 4'(12 + i));
    assign w_fire[i]   = r_tick_q && r_arm[i] && (r_now == r_cmp[i]);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_presc     <= PRESC_DEFAULT;
      r_presc_cnt <= '0;
      r_tick_q    <= 1'b0;
    end else if (w_wr_presc) begin
      r_presc     <= wdata;
      r_presc_cnt <= '0;
      r_tick_q    <= 1'b0;
    end else if (r_en) begin
      if (r_presc_cnt >= r_presc) begin
        r_presc_cnt <= '0;
        r_tick_q    <= 1'b1;
      end else begin
        r_presc_cnt <= r_presc_cnt + 32'd1;
        r_tick_q    <= 1'b0;
      end
    end else begin
      r_tick_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_now <= '0;
    end else if (w_wr_now) begin
      r_now <= wdata;
    end else if (r_tick_q) begin
      r_now <= r_now + 32'd1;
    end
  end

  // Fire sets PEND even when a W1C lands on the same edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_en   <= 1'b0;
      r_ien  <= '0;
      r_pend <= '0;
    end else begin
      if (w_wr_ctrl) r_en <= wdata[0];
      if (w_wr_ien)  r_ien <= wdata[NUM_CH-1:0];
      r_pend <= (r_pend & ~w_w1c) | w_fire;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_arm <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        r_cmp[i]    <= '0;
        r_period[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_wr_ctrl) begin
          r_arm[i] <= wdata[i+1];
        end else if (w_fire[i] && (r_period[i] == 32'd0)) begin
          r_arm[i] <= 1'b0;
        end
        if (w_wr_cmp[i]) begin
          r_cmp[i] <= wdata;
        end else if (w_fire[i] && (r_period[i] != 32'd0)) begin
          r_cmp[i] <= r_cmp[i] + r_period[i];
        end
        if (w_wr_per[i]) r_period[i] <= wdata;
      end
    end
  end

  always_comb begin
    rdata = '0;
    if (cs) begin
      case (w_sel)
        c_A_CTRL:  rdata[NUM_CH:0]   = {r_arm, r_en};
        c_A_PRESC: rdata             = r_presc;
        c_A_NOW:   rdata             = r_now;
        c_A_PEND:  rdata[NUM_CH-1:0] = r_pend;
        c_A_IEN:   rdata[NUM_CH-1:0] = r_ien;
        default:   rdata             = '0;
      endcase
      for (int i = 0; i < NUM_CH; i++) begin
        if (w_sel == 4'(8 + i))  rdata = r_cmp[i];
        if (w_sel == 4'(12 + i)) rdata = r_period[i];
      end
    end
  end

  assign irq      = |(r_pend & r_ien);
  assign tick_out = r_tick_q;

endmodule

`default_nettype wire

// File: doc/timer_alarm_ctrl.md
Name: timer_alarm_ctrl

Overview:
Memory-mapped alarm scheduler that sequences the system tick source. It prescales clk into a tick and keeps a 32-bit tick counter (NOW). NUM_CH compare channels fire one-shot or periodic alarms, each with a pending flag. The block drives a level interrupt to the CPU and sits on the same word-addressed data bus as the other peripherals.

Parameters:
NUM_CH, 4, number of alarm channels (1..4)
PRESC_DEFAULT, 32'h0001_0000, reset value of the PRESC register

Ports:
clk  in  1  system clock
rst  in  1  reset: asynchronous, active-high
cs  in  1  chip select from bus decoder
addr  in  32  byte address; only addr[5:2] decoded
we  in  1  write enable; write occurs at posedge when cs&&we
wdata  in  32  write data
rdata  out  32  read data, combinational
irq  out  1  level interrupt = |(PEND & IEN)
tick_out  out  1  one-cycle tick pulse

Behaviour:
- Register map (word offsets; unmapped or channel i>=NUM_CH: reads 0, writes ignored):
  - 0x00 CTRL: bit0 EN, bits[NUM_CH:1] ARM[i].
  - 0x04 PRESC.
  - 0x08 NOW: R/W.
  - 0x0C PEND: write-1-to-clear.
  - 0x10 IEN.
  - 0x20+4i CMP[i].
  - 0x30+4i PERIOD[i].
- rdata = 0 when cs=0; unused bits read 0.
- Reset (asynchronous): EN=0, ARM=0, PRESC=PRESC_DEFAULT, NOW=0, PEND=0, IEN=0, CMP=0, PERIOD=0, presc_cnt=0, tick_q=0. Outputs irq=0, tick_out=0 immediately. Reset mid-operation aborts everything with no residual pending.
- Prescaler, at each posedge with EN=1:
  - if presc_cnt >= PRESC: presc_cnt<=0, tick_q<=1
  - else: presc_cnt<=presc_cnt+1, tick_q<=0
  - Tick period is PRESC+1 cycles; PRESC=0 gives a tick every cycle.
  - EN=0: presc_cnt and NOW hold, tick_q<=0, PEND/ARM retained.
- A write to PRESC clears presc_cnt to 0 and tick_q to 0 on the same edge.
- tick_out = tick_q.
- Tick cycle (tick_q=1): NOW<=NOW+1 at the next edge, mod 2^32 (0xFFFFFFFF -> 0).
- Match, evaluated in a tick cycle against the pre-increment NOW: channel i fires if ARM[i] && NOW==CMP[i]. Firing, at the next edge:
  - PEND[i]<=1
  - if PERIOD[i]!=0: CMP[i]<=CMP[i]+PERIOD[i] mod 2^32, ARM[i] stays 1
  - else: ARM[i]<=0 (one-shot)
- Multiple channels may fire in the same tick; each acts independently.
- irq is combinational from registers: it rises the cycle after PEND sets and falls the cycle after W1C or an IEN clear.
- Simultaneous events:
  - Bus write to NOW in a tick cycle: write wins, no increment; matches still use the pre-write NOW.
  - Bus write to CMP[i] in its fire cycle: written value wins (no reload); PEND[i] still sets.
  - Bus write to CTRL clearing ARM[i] in its fire cycle: PEND[i] sets, ARM[i]=0.
  - W1C of PEND[i] in the same cycle channel i fires: set wins, PEND[i]=1.
  - Write to CTRL with ARM[i]=1 and CMP[i] already in the past: the channel fires only after NOW wraps to CMP[i].

Test Plan:
- Reset then reads at 0x04/0x08/0x0C/0x00 -> 0x00010000/0/0/0; irq=0, tick_out=0; read with cs=0 -> 0.
- PRESC=3, CTRL=0x1 -> tick_out one-cycle pulse every 4 cycles; after 5 pulses NOW reads 5. Clear EN -> NOW frozen at 5, no pulses.
- PRESC=0, CMP0=10, IEN=1, CTRL=0x3 -> PEND bit0=1 the cycle after the tick with NOW==10; irq=1; CTRL reads 0x1 (ARM0 cleared). Write PEND=1 -> irq=0 next cycle, no refire at NOW=10+2^32 until re-armed.
- CMP1=5, PERIOD1=8, ARM1, IEN=2 -> fires at NOW=5, 13, 21 (clear PEND between); CMP1 then reads 29.
- Wrap: NOW=0xFFFFFFFE, CMP2=1, one-shot ARM2, PRESC=0 -> NOW goes 0xFFFFFFFF, 0, 1; PEND bit2 set after tick at NOW=1. Also CMP3=0xFFFFFFFF, PERIOD3=2 -> CMP3 reloads to 1.
- Collisions:
  - W1C PEND0 on channel 0's fire cycle -> PEND0 stays 1.
  - CMP0 write on fire cycle -> CMP0 = written value.
  - Async rst pulse while irq=1 -> irq=0 within the same cycle, all registers at reset values.
